// File: rtl/bus_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_ctrl_pkg : bus source/destination codes, command kinds, sequencer states
// Revision 1.0
// ---------------------------------------------------------------------------
package bus_ctrl_pkg;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_C      = 22;
  localparam int SRC_INPORT = 23;
  localparam int NUM_SRC    = 24;

  localparam int DEST_HI    = 16;
  localparam int DEST_LO    = 17;
  localparam int NUM_DEST   = 18;

  typedef enum logic [1:0] {
    KIND_MOVE = 2'd0,
    KIND_ALU  = 2'd1,
    KIND_WIDE = 2'd2,
    KIND_RSVD = 2'd3
  } cmd_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MOVE  = 3'd1,
    ST_OPA   = 3'd2,
    ST_OPB   = 3'd3,
    ST_WB_LO = 3'd4,
    ST_WB_HI = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/bus_src_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_src_decoder : binary code to one-hot enable; codes >= OUT_W give zero
// Revision 1.0
// ---------------------------------------------------------------------------
module bus_src_decoder
  import bus_ctrl_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = NUM_SRC
) (
  input  logic             en_i,
  input  logic [IN_W-1:0]  code_i,
  output logic [OUT_W-1:0] onehot_o
);

  for (genvar g = 0; g < OUT_W; g++) begin : g_bit
    assign onehot_o[g] = en_i && (code_i == IN_W'(g));
  end

endmodule
`default_nettype wire

// File: rtl/bus_transfer_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_transfer_sequencer : steps one register-transfer command over the bus
// Revision 1.0
// ---------------------------------------------------------------------------
module bus_transfer_sequencer
  import bus_ctrl_pkg::*;
#(
  parameter int SRC_W    = 5,
  parameter int ALU_OP_W = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_kind,
  input  logic [SRC_W-1:0]    cmd_src_a,
  input  logic [SRC_W-1:0]    cmd_src_b,
  input  logic [SRC_W-1:0]    cmd_dest,
  input  logic [ALU_OP_W-1:0] cmd_alu_op,
  input  logic                abort,
  output logic [NUM_SRC-1:0]  src_out,
  output logic                y_in,
  output logic                z_in,
  output logic [NUM_DEST-1:0] dest_in,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                done,
  output logic                err
);

  state_e                state_q, state_d;
  cmd_kind_e             kind_q, kind_d, kind_in;
  logic [SRC_W-1:0]      src_a_q, src_a_d, src_b_q, src_b_d, dest_q, dest_d;
  logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
  logic                  accept, cmd_ok;
  logic                  src_en, dest_en;
  logic [SRC_W-1:0]      src_sel, dest_sel;
  logic [NUM_SRC-1:0]    src_dec, src_out_q;
  logic [NUM_DEST-1:0]   dest_dec, dest_in_q;
  logic                  y_d, z_d, done_d, err_d;
  logic                  y_q, z_q, done_q, err_q;

  assign kind_in   = cmd_kind_e'(cmd_kind);
  assign cmd_ready = (state_q == ST_IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;

  assign cmd_ok = (kind_in != KIND_RSVD)
               && (cmd_src_a < SRC_W'(NUM_SRC))
               && ((kind_in == KIND_WIDE) || (cmd_dest < SRC_W'(NUM_DEST)))
               && ((kind_in == KIND_MOVE) || (cmd_src_b < SRC_W'(NUM_SRC)));

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    dest_d   = dest_q;
    alu_op_d = alu_op_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            kind_d   = kind_in;
            src_a_d  = cmd_src_a;
            src_b_d  = cmd_src_b;
            dest_d   = cmd_dest;
            alu_op_d = cmd_alu_op;
            if (!cmd_ok)                    state_d = ST_ERR;
            else if (kind_in == KIND_MOVE)  state_d = ST_MOVE;
            else                            state_d = ST_OPA;
          end
        end
        ST_OPA:   state_d = ST_OPB;
        ST_OPB:   state_d = ST_WB_LO;
        ST_WB_LO: state_d = (kind_q == KIND_WIDE) ? ST_WB_HI : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so that they are registered
  // together with it and appear in the same cycle as the state they describe.
  always_comb begin
    src_en   = 1'b0;
    src_sel  = src_a_d;
    dest_en  = 1'b0;
    dest_sel = dest_d;
    y_d      = 1'b0;
    z_d      = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_d)
      ST_MOVE: begin
        src_en  = 1'b1;
        dest_en = 1'b1;
        done_d  = 1'b1;
      end
      ST_OPA: begin
        src_en = 1'b1;
        y_d    = 1'b1;
      end
      ST_OPB: begin
        src_en  = 1'b1;
        src_sel = src_b_d;
        z_d     = 1'b1;
      end
      ST_WB_LO: begin
        src_en  = 1'b1;
        src_sel = SRC_W'(SRC_ZLO);
        dest_en = 1'b1;
        if (kind_d == KIND_WIDE) begin
          dest_sel = SRC_W'(DEST_LO);
        end else begin
          done_d = 1'b1;
        end
      end
      ST_WB_HI: begin
        src_en   = 1'b1;
        src_sel  = SRC_W'(SRC_ZHI);
        dest_en  = 1'b1;
        dest_sel = SRC_W'(DEST_HI);
        done_d   = 1'b1;
      end
      ST_ERR:  err_d = 1'b1;
      default: ;
    endcase
  end

  bus_src_decoder #(.IN_W(SRC_W), .OUT_W(NUM_SRC)) u_src_dec (
    .en_i     (src_en),
    .code_i   (src_sel),
    .onehot_o (src_dec)
  );

  bus_src_decoder #(.IN_W(SRC_W), .OUT_W(NUM_DEST)) u_dest_dec (
    .en_i     (dest_en),
    .code_i   (dest_sel),
    .onehot_o (dest_dec)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      kind_q    <= KIND_MOVE;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dest_q    <= '0;
      alu_op_q  <= '0;
      src_out_q <= '0;
      dest_in_q <= '0;
      y_q       <= 1'b0;
      z_q       <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      kind_q    <= kind_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      dest_q    <= dest_d;
      alu_op_q  <= alu_op_d;
      src_out_q <= src_dec;
      dest_in_q <= dest_dec;
      y_q       <= y_d;
      z_q       <= z_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign src_out = src_out_q;
  assign dest_in = dest_in_q;
  assign y_in    = y_q;
  assign z_in    = z_q;
  assign done    = done_q;
  assign err     = err_q;
  assign alu_op  = alu_op_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_transfer_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bus_transfer_sequencer : directed and random checks against a step model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_bus_transfer_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_kind = '0;
  logic [4:0]  cmd_src_a = '0, cmd_src_b = '0, cmd_dest = '0;
  logic [4:0]  cmd_alu_op = '0;
  logic        abort = 1'b0;
  logic [23:0] src_out;
  logic        y_in, z_in;
  logic [17:0] dest_in;
  logic [4:0]  alu_op;
  logic        done, err;

  int tests = 0;
  int fails = 0;

  bus_transfer_sequencer #(.SRC_W(5), .ALU_OP_W(5)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_kind   (cmd_kind),
    .cmd_src_a  (cmd_src_a),
    .cmd_src_b  (cmd_src_b),
    .cmd_dest   (cmd_dest),
    .cmd_alu_op (cmd_alu_op),
    .abort      (abort),
    .src_out    (src_out),
    .y_in       (y_in),
    .z_in       (z_in),
    .dest_in    (dest_in),
    .alu_op     (alu_op),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted command becomes a list of bus steps; one step per cycle.
  typedef struct packed {
    logic [23:0] src;
    logic [17:0] dst;
    logic        y, z, dn, er;
  } step_t;

  step_t  pend[$];
  step_t  cur = '0;
  bit     have_cur = 1'b0;
  logic [4:0] exp_alu = '0;
  int     accepted = 0;

  function automatic step_t mk(int s, int d, bit y, bit z, bit dn, bit er);
    step_t t;
    t.src = (s >= 0) ? (24'(1) << s) : 24'(0);
    t.dst = (d >= 0) ? (18'(1) << d) : 18'(0);
    t.y = y; t.z = z; t.dn = dn; t.er = er;
    return t;
  endfunction

  task automatic build(input int k, input int a, input int b, input int d);
    bit bad;
    bad = (k == 3) || (a >= 24) || (k != 2 && d >= 18) || (k != 0 && b >= 24);
    if (bad) pend.push_back(mk(-1, -1, 0, 0, 0, 1));
    else if (k == 0) pend.push_back(mk(a, d, 0, 0, 1, 0));
    else begin
      pend.push_back(mk(a, -1, 1, 0, 0, 0));
      pend.push_back(mk(b, -1, 0, 1, 0, 0));
      if (k == 1) pend.push_back(mk(19, d, 0, 0, 1, 0));
      else begin
        pend.push_back(mk(19, 17, 0, 0, 0, 0));
        pend.push_back(mk(18, 16, 0, 0, 1, 0));
      end
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend.delete();
      have_cur = 1'b0;
      exp_alu  = '0;
    end else if (abort) begin
      pend.delete();
      have_cur = 1'b0;
    end else if (!have_cur && cmd_valid) begin
      exp_alu = cmd_alu_op;
      build(int'(cmd_kind), int'(cmd_src_a), int'(cmd_src_b), int'(cmd_dest));
      cur = pend.pop_front();
      have_cur = 1'b1;
      accepted++;
    end else if (pend.size() > 0) begin
      cur = pend.pop_front();
      have_cur = 1'b1;
    end else begin
      have_cur = 1'b0;
    end
  end

  always @(negedge clock) begin
    step_t e;
    e = have_cur ? cur : '0;
    chk("src_out", 32'(src_out), 32'(e.src));
    chk("dest_in", 32'(dest_in), 32'(e.dst));
    chk("y_in", 32'(y_in), 32'(e.y));
    chk("z_in", 32'(z_in), 32'(e.z));
    chk("done", 32'(done), 32'(e.dn));
    chk("err", 32'(err), 32'(e.er));
    chk("alu_op", 32'(alu_op), 32'(exp_alu));
    chk("onehot", 32'($countones(src_out) <= 1), 32'd1);
    if (reset_n) chk("cmd_ready", 32'(cmd_ready), 32'(!have_cur && !abort));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int k, input int a, input int b, input int d, input int op);
    for (int i = 0; i < 20 && !cmd_ready; i++) step();
    chk("ready_before_send", 32'(cmd_ready), 32'd1);
    cmd_kind   = k[1:0];
    cmd_src_a  = a[4:0];
    cmd_src_b  = b[4:0];
    cmd_dest   = d[4:0];
    cmd_alu_op = op[4:0];
    cmd_valid  = 1'b1;
    step();
    cmd_valid  = 1'b0;
  endtask

  task automatic chk_bus(input string nm, input logic [23:0] s, input logic [17:0] d,
                         input bit y, input bit z, input bit dn, input bit er);
    chk({nm, ".src"}, 32'(src_out), 32'(s));
    chk({nm, ".dst"}, 32'(dest_in), 32'(d));
    chk({nm, ".yz"}, {30'd0, y_in, z_in}, {30'd0, y, z});
    chk({nm, ".done"}, 32'(done), 32'(dn));
    chk({nm, ".err"}, 32'(err), 32'(er));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    step(); step();
    chk_bus("reset", 24'h0, 18'h0, 0, 0, 0, 0);
    chk("reset.alu_op", 32'(alu_op), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("reset.ready", 32'(cmd_ready), 32'd1);
    step();

    // MOVE MDR -> R3
    send(0, 21, 0, 3, 0);
    chk_bus("move", 24'h20_0000, 18'h8, 0, 0, 1, 0);
    chk("move.busy", 32'(cmd_ready), 32'd0);
    step();
    chk("move.ready", 32'(cmd_ready), 32'd1);

    // ALU R1 op R2 -> R5
    send(1, 1, 2, 5, 3);
    chk_bus("alu.opa", 24'h2, 18'h0, 1, 0, 0, 0);
    chk("alu.op", 32'(alu_op), 32'd3);
    step();
    chk_bus("alu.opb", 24'h4, 18'h0, 0, 1, 0, 0);
    step();
    chk_bus("alu.wb", 24'h8_0000, 18'h20, 0, 0, 1, 0);
    chk("alu.op2", 32'(alu_op), 32'd3);
    step();

    // WIDE R6, R7 -> LO/HI
    send(2, 6, 7, 9, 4);
    chk_bus("wide.opa", 24'h40, 18'h0, 1, 0, 0, 0);
    step();
    chk_bus("wide.opb", 24'h80, 18'h0, 0, 1, 0, 0);
    step();
    chk_bus("wide.lo", 24'h8_0000, 18'h2_0000, 0, 0, 0, 0);
    step();
    chk_bus("wide.hi", 24'h4_0000, 18'h1_0000, 0, 0, 1, 0);
    step();

    // Rejected commands
    send(0, 25, 0, 1, 0);
    chk_bus("inv.src", 24'h0, 18'h0, 0, 0, 0, 1);
    step();
    chk("inv.src.ready", 32'(cmd_ready), 32'd1);
    send(1, 1, 2, 20, 0);
    chk_bus("inv.dest", 24'h0, 18'h0, 0, 0, 0, 1);
    step();
    send(3, 0, 0, 0, 0);
    chk_bus("inv.kind", 24'h0, 18'h0, 0, 0, 0, 1);
    step();
    chk_bus("inv.after", 24'h0, 18'h0, 0, 0, 0, 0);

    // Abort in OPB, then abort held together with a valid command
    send(1, 1, 2, 5, 7);
    step();
    chk_bus("abort.opb", 24'h4, 18'h0, 0, 1, 0, 0);
    abort = 1'b1; cmd_valid = 1'b1;
    cmd_kind = 2'd0; cmd_src_a = 5'd21; cmd_dest = 5'd3;
    step();
    chk_bus("abort.flush", 24'h0, 18'h0, 0, 0, 0, 0);
    chk("abort.ready", 32'(cmd_ready), 32'd0);
    step();
    chk_bus("abort.noacc", 24'h0, 18'h0, 0, 0, 0, 0);
    abort = 1'b0; cmd_valid = 1'b0;
    #1;
    chk("abort.ready2", 32'(cmd_ready), 32'd1);
    step();
    chk_bus("abort.idle", 24'h0, 18'h0, 0, 0, 0, 0);

    // Asynchronous reset during WIDE write-back
    send(2, 6, 7, 0, 9);
    step(); step();
    chk_bus("rst.wblo", 24'h8_0000, 18'h2_0000, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk_bus("rst.async", 24'h0, 18'h0, 0, 0, 0, 0);
    chk("rst.alu_op", 32'(alu_op), 32'd0);
    #3 reset_n = 1'b1;
    step();
    chk_bus("rst.nohi", 24'h0, 18'h0, 0, 0, 0, 0);
    chk("rst.ready", 32'(cmd_ready), 32'd1);

    // Random traffic, checked every cycle by the model
    for (int cyc = 0; cyc < 30000 && accepted < 1010; cyc++) begin
      cmd_valid  = ($urandom_range(0, 1) == 1);
      cmd_kind   = 2'($urandom_range(0, 3));
      cmd_src_a  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 23));
      cmd_src_b  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 23));
      cmd_dest   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 17));
      cmd_alu_op = 5'($urandom_range(0, 31));
      abort      = ($urandom_range(0, 19) == 0);
      step();
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    chk("random.count", 32'(accepted >= 1010), 32'd1);
    step(); step(); step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_transfer_sequencer.md
# bus_transfer_sequencer

Microstep sequencer that drives the 24 out-enables of the 32-to-1 datapath bus mux, plus the Y/Z/destination load strobes, for one register-transfer command at a time. It accepts a command through a valid/ready handshake and steps it through one to four bus cycles. It guarantees at most one bus source is enabled per cycle. It sits between the control unit and the bus mux, register file, and Y/Z/HI/LO registers.

## Interface
- `SRC_W`, 5: width of source/destination codes.
- `ALU_OP_W`, 5: width of the passed-through ALU opcode.
- `clock`  in  1  single system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_kind`  in  2  0 MOVE, 1 ALU, 2 WIDE, 3 reserved.
- `cmd_src_a`, `cmd_src_b`  in  SRC_W  source codes.
  - 0–15: R0–R15.
  - 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 C, 23 INPORT.
  - 24–31: invalid.
- `cmd_dest`  in  SRC_W  destination code: 0–15 R0–R15, 16 HI, 17 LO; 18–31 invalid.
- `cmd_alu_op`  in  ALU_OP_W  ALU opcode for ALU/WIDE.
- `abort`  in  1  synchronous flush.
- `src_out`  out  24  one-hot bus-mux out-enables, bit index equals source code.
- `y_in`, `z_in`  out  1  Y and Z register load strobes.
- `dest_in`  out  18  destination load enables, bit index equals destination code.
- `alu_op`  out  ALU_OP_W  registered opcode to the ALU.
- `done`  out  1  one-cycle pulse in the last step of a valid command.
- `err`  out  1  one-cycle pulse for a rejected command.

## Operation
- States: IDLE, MOVE, OPA, OPB, WB_LO, WB_HI, ERR.
- `cmd_ready` = (state == IDLE) && !abort.
- A command is accepted on an edge where `cmd_valid && cmd_ready`. All fields are captured on that edge.
- Validity check at accept:
  - `cmd_kind` 3 is invalid.
  - `cmd_src_a` ≥ 24 is invalid.
  - `cmd_dest` ≥ 18 is invalid for MOVE and ALU.
  - `cmd_src_b` ≥ 24 is invalid for ALU and WIDE.
  - `cmd_src_b` is ignored for MOVE; `cmd_dest` is ignored for WIDE.
  - Any invalid field sends the FSM to ERR.
- Per-state outputs. Anything not listed is 0.
  - MOVE: `src_out[src_a]`, `dest_in[dest]`, `done`. Next state IDLE.
  - OPA: `src_out[src_a]`, `y_in`. Next state OPB.
  - OPB: `src_out[src_b]`, `z_in`. Next state WB_LO.
  - WB_LO, ALU command: `src_out[19]` (ZLO), `dest_in[dest]`, `done`. Next state IDLE.
  - WB_LO, WIDE command: `src_out[19]`, `dest_in[17]` (LO). Next state WB_HI.
  - WB_HI: `src_out[18]` (ZHI), `dest_in[16]` (HI), `done`. Next state IDLE.
  - ERR: `err`. Next state IDLE.
- `alu_op` loads on accept. It holds until the next accept and is not cleared on return to IDLE.
- `abort` takes priority over everything. On the next edge the state is IDLE and all strobes are 0. No `done` is issued for the aborted command. `abort` together with `cmd_valid` accepts nothing.
- `popcount(src_out)` ≤ 1 in every cycle (invariant).

## Timing
- All outputs are registered, decoded from the state register.
- Accept at edge k: the first step is visible during cycle k+1.
- Latency from accept edge to the `done` cycle: MOVE 1, ALU 3, WIDE 4, ERR 1 (`err` in place of `done`).
- `cmd_ready` rises in the cycle after the `done`/`err` cycle. There is no overlap between commands.
- Reset (asynchronous, any time, including mid-command): state IDLE; `src_out`, `y_in`, `z_in`, `dest_in`, `done`, `err` all 0; `alu_op` 0. `cmd_ready` is 1 once `reset_n` is high.
- A command is discarded by reset with no partial step after release.

## Structure
- Package `bus_ctrl_pkg` holds:
  - source-code localparams (R0..INPORT, `NUM_SRC` = 24);
  - destination codes (`DEST_HI` = 16, `DEST_LO` = 17, `NUM_DEST` = 18);
  - the `cmd_kind` enum;
  - the FSM state enum.
- Sub-module `bus_src_decoder`: combinational SRC_W-to-24 one-hot decoder with an enable input. It outputs all zeros for codes ≥ 24. It is reused for `dest_in` with width 18.

## Test plan
- After reset: MOVE src_a=21 (MDR), dest=3 accepted at edge k -> cycle k+1 has `src_out`=1<<21, `dest_in`=1<<3, `done`=1; `cmd_ready`=1 at k+2.
- ALU src_a=1, src_b=2, dest=5, alu_op=3 -> successive cycles:
  - `src_out`=1<<1 with `y_in`;
  - then 1<<2 with `z_in`;
  - then 1<<19 with `dest_in`=1<<5 and `done`.
  - `alu_op`=3 throughout.
- WIDE src_a=6, src_b=7 -> four steps, ending with ZLO→LO (`dest_in`=1<<17), then ZHI→HI (`dest_in`=1<<16) with `done`.
- Invalid commands -> one `err` pulse, zero enables, back to IDLE:
  - MOVE src_a=25;
  - ALU dest=20;
  - kind=3.
- `abort` asserted during OPB of an ALU command -> next cycle all strobes 0, no `done`; `abort` with `cmd_valid` -> not accepted.
- `reset_n` low during WB_LO of WIDE -> outputs 0 immediately (asynchronously); after release, no WB_HI step occurs and `cmd_ready`=1. The one-hot `src_out` assertion holds across 1000 random commands.
